// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard control bus between ID/EX/MEM stages and hazard_ctrl
interface hazard_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic              id_rs1_read;
  logic              id_rs2_read;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic              ex_valid;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_redirect;
  logic [XLEN-1:0]   ex_redirect_pc;
  logic              mem_busy;

  logic              if_redirect;
  logic [XLEN-1:0]   if_redirect_pc;
  logic              if_flush;
  logic              id_flush;
  logic              id_hold;
  logic              ex_bubble;
  logic              ex_hold;

  // master: the pipeline stages; slave: the hazard controller
  modport master (
    output id_valid, id_rs1_read, id_rs2_read, id_rs1_addr, id_rs2_addr,
    output ex_valid, ex_mem_read, ex_rd_addr, ex_redirect, ex_redirect_pc,
    output mem_busy,
    input  if_redirect, if_redirect_pc, if_flush, id_flush, id_hold,
    input  ex_bubble, ex_hold
  );

  modport slave (
    input  id_valid, id_rs1_read, id_rs2_read, id_rs1_addr, id_rs2_addr,
    input  ex_valid, ex_mem_read, ex_rd_addr, ex_redirect, ex_redirect_pc,
    input  mem_busy,
    output if_redirect, if_redirect_pc, if_flush, id_flush, id_hold,
    output ex_bubble, ex_hold
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, redirect/flush sequencing and MEM back-pressure for the 5-stage core
module hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        fcnt;
  logic              redirect_q;
  logic [XLEN-1:0]   redirect_pc_q;

  logic              rs1_match;
  logic              rs2_match;
  logic              lu_hazard;
  logic              redirect_acc;
  logic              in_flush;

  logic              if_flush_c;
  logic              id_flush_c;
  logic              id_hold_c;
  logic              ex_bubble_c;
  logic              ex_hold_c;

  assign rs1_match = hz.id_rs1_read & (hz.id_rs1_addr == hz.ex_rd_addr);
  assign rs2_match = hz.id_rs2_read & (hz.id_rs2_addr == hz.ex_rd_addr);

  assign lu_hazard = hz.id_valid & hz.ex_valid & hz.ex_mem_read &
                     (hz.ex_rd_addr != REG_AW'(0)) & (rs1_match | rs2_match);

  // A branch stalled behind a busy MEM stays in EX and is taken once MEM frees up.
  assign redirect_acc = hz.ex_redirect & ~hz.mem_busy;
  assign in_flush     = (state == ST_FLUSH);

  always_comb begin
    if_flush_c  = 1'b0;
    id_flush_c  = 1'b0;
    id_hold_c   = 1'b0;
    ex_bubble_c = 1'b0;
    ex_hold_c   = 1'b0;

    if (hz.mem_busy) begin
      ex_hold_c = 1'b1;
      id_hold_c = 1'b1;
    end else if (redirect_acc) begin
      if_flush_c = 1'b1;
      id_flush_c = 1'b1;
    end else if (!in_flush && lu_hazard) begin
      id_hold_c   = 1'b1;
      ex_bubble_c = 1'b1;
    end

    // The wrong-path window keeps killing IF/ID even while MEM back-pressures.
    if (in_flush) begin
      if_flush_c = 1'b1;
      id_flush_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      fcnt          <= 3'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
    end else begin
      redirect_q <= redirect_acc;
      if (redirect_acc) begin
        redirect_pc_q <= hz.ex_redirect_pc;
      end

      if (redirect_acc) begin
        state <= ST_FLUSH;
        fcnt  <= 3'(FLUSH_CYCLES);
      end else if (in_flush) begin
        if (fcnt == 3'd1) begin
          state <= ST_RUN;
          fcnt  <= 3'd0;
        end else begin
          fcnt <= fcnt - 3'd1;
        end
      end

      if (id_hold_c && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect_acc && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.if_redirect    = redirect_q;
  assign hz.if_redirect_pc = redirect_pc_q;
  assign hz.if_flush       = if_flush_c;
  assign hz.id_flush       = id_flush_c;
  assign hz.id_hold        = id_hold_c;
  assign hz.ex_bubble      = ex_bubble_c;
  assign hz.ex_hold        = ex_hold_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(32), .REG_AW(5)) h ();
  hazard_ctrl_if #(.XLEN(32), .REG_AW(5)) h4 ();

  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [3:0]  stall_cnt4;
  logic [3:0]  flush_cnt4;

  hazard_ctrl #(.XLEN(32), .REG_AW(5), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(h), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.XLEN(32), .REG_AW(5), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hz(h4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // The narrow-counter instance sees exactly the same pipeline inputs.
  assign h4.id_valid       = h.id_valid;
  assign h4.id_rs1_read    = h.id_rs1_read;
  assign h4.id_rs2_read    = h.id_rs2_read;
  assign h4.id_rs1_addr    = h.id_rs1_addr;
  assign h4.id_rs2_addr    = h.id_rs2_addr;
  assign h4.ex_valid       = h.ex_valid;
  assign h4.ex_mem_read    = h.ex_mem_read;
  assign h4.ex_rd_addr     = h.ex_rd_addr;
  assign h4.ex_redirect    = h.ex_redirect;
  assign h4.ex_redirect_pc = h.ex_redirect_pc;
  assign h4.mem_busy       = h.mem_busy;

  typedef struct {
    string       name;
    logic [4:0]  flags;   // {if_flush, id_flush, id_hold, ex_bubble, ex_hold}
    logic        ifr;
    logic [31:0] pc;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [3:0]  stall4;
    logic [3:0]  flush4;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h.id_valid       = 1'b0;
    h.id_rs1_read    = 1'b0;
    h.id_rs2_read    = 1'b0;
    h.id_rs1_addr    = 5'd0;
    h.id_rs2_addr    = 5'd0;
    h.ex_valid       = 1'b0;
    h.ex_mem_read    = 1'b0;
    h.ex_rd_addr     = 5'd0;
    h.ex_redirect    = 1'b0;
    h.ex_redirect_pc = 32'd0;
    h.mem_busy       = 1'b0;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    h.ex_valid    = 1'b1;
    h.ex_mem_read = 1'b1;
    h.ex_rd_addr  = rd;
  endtask

  task automatic expect_cycle(input string nm, input logic [4:0] f, input logic r,
                              input logic [31:0] p, input int s, input int fl);
    exp_t e;
    e.name   = nm;
    e.flags  = f;
    e.ifr    = r;
    e.pc     = p;
    e.stall  = 32'(s);
    e.flush  = 32'(fl);
    e.stall4 = (s > 15) ? 4'd15 : 4'(s);
    e.flush4 = (fl > 15) ? 4'd15 : 4'(fl);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] act_flags;
      e = exp_q.pop_front();
      act_flags = {h.if_flush, h.id_flush, h.id_hold, h.ex_bubble, h.ex_hold};

      checks++;
      if (act_flags !== e.flags) begin
        failures++;
        $display("FAIL %s flags: got %b want %b", e.name, act_flags, e.flags);
      end
      checks++;
      if ({h.if_redirect, h.if_redirect_pc} !== {e.ifr, e.pc}) begin
        failures++;
        $display("FAIL %s redirect: got %b/%h want %b/%h", e.name,
                 h.if_redirect, h.if_redirect_pc, e.ifr, e.pc);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== {e.stall, e.flush}) begin
        failures++;
        $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 e.name, stall_cnt, flush_cnt, e.stall, e.flush);
      end
      checks++;
      if ({stall_cnt4, flush_cnt4} !== {e.stall4, e.flush4}) begin
        failures++;
        $display("FAIL %s narrow_counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 e.name, stall_cnt4, flush_cnt4, e.stall4, e.flush4);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();

    tick(); expect_cycle("reset", 5'b00000, 0, 32'h0, 0, 0);
    tick(); rst = 1'b0; expect_cycle("idle", 5'b00000, 0, 32'h0, 0, 0);

    // Load-use hazards
    tick(); load_in_ex(5'd5); h.id_valid = 1; h.id_rs2_read = 1; h.id_rs2_addr = 5'd5;
    expect_cycle("lu_rs2", 5'b00110, 0, 32'h0, 0, 0);
    tick(); idle(); expect_cycle("after_lu", 5'b00000, 0, 32'h0, 1, 0);
    tick(); load_in_ex(5'd0); h.id_valid = 1; h.id_rs2_read = 1; h.id_rs2_addr = 5'd0;
    expect_cycle("lu_x0", 5'b00000, 0, 32'h0, 1, 0);
    tick(); idle(); load_in_ex(5'd7); h.id_valid = 1; h.id_rs1_addr = 5'd7;
    expect_cycle("lu_no_read", 5'b00000, 0, 32'h0, 1, 0);
    tick(); idle(); h.ex_valid = 1; h.ex_rd_addr = 5'd7; h.id_valid = 1;
    h.id_rs1_read = 1; h.id_rs1_addr = 5'd7;
    expect_cycle("no_load", 5'b00000, 0, 32'h0, 1, 0);
    tick(); h.ex_mem_read = 1;
    expect_cycle("lu_rs1", 5'b00110, 0, 32'h0, 1, 0);
    tick(); idle(); expect_cycle("after_lu2", 5'b00000, 0, 32'h0, 2, 0);

    // Redirect with a simultaneous load-use: redirect wins
    tick(); load_in_ex(5'd7); h.id_valid = 1; h.id_rs1_read = 1; h.id_rs1_addr = 5'd7;
    h.ex_redirect = 1; h.ex_redirect_pc = 32'h100;
    expect_cycle("redir_T", 5'b11000, 0, 32'h0, 2, 0);
    tick(); idle(); expect_cycle("redir_T1", 5'b11000, 1, 32'h100, 2, 1);
    tick(); load_in_ex(5'd7); h.id_valid = 1; h.id_rs1_read = 1; h.id_rs1_addr = 5'd7;
    expect_cycle("redir_T2_masked", 5'b11000, 0, 32'h100, 2, 1);
    tick(); idle(); expect_cycle("redir_T3_run", 5'b00000, 0, 32'h100, 2, 1);

    // Redirect blocked by mem_busy for three cycles
    for (int i = 0; i < 3; i++) begin
      tick(); h.ex_redirect = 1; h.ex_redirect_pc = 32'h300; h.mem_busy = 1;
      expect_cycle("busy_block", 5'b00101, 0, 32'h100, 2 + i, 1);
    end
    tick(); h.mem_busy = 0;
    expect_cycle("busy_release", 5'b11000, 0, 32'h100, 5, 1);
    tick(); idle(); expect_cycle("busy_T1", 5'b11000, 1, 32'h300, 5, 2);
    tick(); expect_cycle("busy_T2", 5'b11000, 0, 32'h300, 5, 2);
    tick(); expect_cycle("busy_T3", 5'b00000, 0, 32'h300, 5, 2);

    // Back-to-back redirects; fcnt keeps counting under mem_busy
    tick(); h.ex_redirect = 1; h.ex_redirect_pc = 32'h100;
    expect_cycle("b2b_T", 5'b11000, 0, 32'h300, 5, 2);
    tick(); h.ex_redirect_pc = 32'h200;
    expect_cycle("b2b_T1", 5'b11000, 1, 32'h100, 5, 3);
    tick(); idle(); expect_cycle("b2b_T2", 5'b11000, 1, 32'h200, 5, 4);
    tick(); h.mem_busy = 1; expect_cycle("b2b_T3_busy", 5'b11101, 0, 32'h200, 5, 4);
    tick(); idle(); expect_cycle("b2b_T4_run", 5'b00000, 0, 32'h200, 6, 4);

    // Reset inside FLUSH drops a redirect presented on the reset edge
    tick(); h.ex_redirect = 1; h.ex_redirect_pc = 32'h400;
    expect_cycle("rst_T", 5'b11000, 0, 32'h200, 6, 4);
    tick(); rst = 1; h.ex_redirect_pc = 32'h500;
    expect_cycle("rst_T1", 5'b11000, 1, 32'h400, 6, 5);
    tick(); rst = 0; idle(); expect_cycle("rst_T2", 5'b00000, 0, 32'h0, 0, 0);

    // Stall counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      tick(); h.mem_busy = 1;
      expect_cycle("sat_busy", 5'b00101, 0, 32'h0, i, 0);
    end
    tick(); idle(); expect_cycle("sat_end", 5'b00000, 0, 32'h0, 20, 0);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
